// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the parametrised inter-stage register chain of the
// 5-stage MIPS datapath.
//   MAX_DEPTH      : largest legal chain depth
//   STG_FD..STG_MW : stage indices of the classic fetch/decode, decode/execute,
//                    execute/memory and memory/writeback registers
//   DEF_BUBBLE_VAL : default payload for bubbles; all-zero keeps RegWrite,
//                    MemWrite and Branch inactive
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int MAX_DEPTH = 8;

    localparam int STG_FD = 0;
    localparam int STG_DE = 1;
    localparam int STG_EM = 2;
    localparam int STG_MW = 3;

    localparam int DEF_BUBBLE_VAL = 0;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// One pipeline register: WIDTH-bit payload plus valid bit, with the
// flush / hold / bubble / load selection applied at each rising edge.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high; loads BUBBLE_VAL, clears valid
//   flush      in   kill this stage at the next edge (beats hold)
//   hold       in   keep current contents
//   up_hold    in   upstream stage is frozen; insert a bubble
//   prev_data  in   payload offered by the upstream stage (or the input)
//   prev_valid in   valid bit offered by the upstream stage (or the input)
//   data       out  registered payload
//   valid      out  registered valid bit
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             up_hold,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= BUBBLE_VAL;
            valid <= 1'b0;
        end else if (flush) begin
            data  <= BUBBLE_VAL;
            valid <= 1'b0;
        end else if (hold) begin
            data  <= data;
            valid <= valid;
        end else if (up_hold || !prev_valid) begin
            // Bubble: either upstream is frozen, or the offered entry is not a
            // real instruction. Invalid payloads never travel down the chain.
            data  <= BUBBLE_VAL;
            valid <= 1'b0;
        end else begin
            data  <= prev_data;
            valid <= 1'b1;
        end
    end

endmodule : pipe_stage_reg

// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
// DEPTH-long chain of WIDTH-bit pipeline registers with per-stage stall and
// flush, replacing the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// A stall on stage k freezes stage k and every earlier stage; the first stage
// downstream of a frozen stage receives a bubble.
// Optional feature macro: PIPE_PERF_CNT_EN (adds CNT_W, stall_cnt, bubble_cnt).
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high; clears the whole chain
//   in_data     in   payload entering stage 0
//   in_valid    in   in_data is a real instruction
//   in_ready    out  stage 0 accepts this cycle (PC may advance)
//   stall_i     in   stall_i[k] freezes stage k and all earlier stages
//   flush_i     in   flush_i[k] kills stage k at the next edge
//   stage_data  out  bits [k*WIDTH +: WIDTH] are the stage k register
//   stage_valid out  valid bit of stage k
//   stall_cnt   out  saturating count of cycles with in_ready low
//   bubble_cnt  out  saturating count of cycles with a bubble inserted or a
//                    valid stage flushed
// -----------------------------------------------------------------------------
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(DEF_BUBBLE_VAL)
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int               CNT_W      = 16
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall_i,
    input  logic [DEPTH-1:0]       flush_i,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [DEPTH-1:0]       stage_valid
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt
`endif
);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_check
        $error("pipe_reg_chain: DEPTH out of range 1..MAX_DEPTH");
    end

    // hold[k] = OR of stall_i[k..DEPTH-1]; built as a suffix-OR from the tail.
    logic [DEPTH-1:0] hold;

    always_comb begin
        hold            = '0;
        hold[DEPTH-1]   = stall_i[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold[k] = stall_i[k] | hold[k + 1];
        end
    end

    assign in_ready = ~hold[STG_FD];

    // Per-stage registers; stage 0 is fed by the input port.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_stage_reg #(
                .WIDTH      (WIDTH),
                .BUBBLE_VAL (BUBBLE_VAL)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .flush      (flush_i[k]),
                .hold       (hold[k]),
                .up_hold    (1'b0),
                .prev_data  (in_data),
                .prev_valid (in_valid),
                .data       (stage_data[k*WIDTH +: WIDTH]),
                .valid      (stage_valid[k])
            );
        end else begin : g_next
            pipe_stage_reg #(
                .WIDTH      (WIDTH),
                .BUBBLE_VAL (BUBBLE_VAL)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .flush      (flush_i[k]),
                .hold       (hold[k]),
                .up_hold    (hold[k-1]),
                .prev_data  (stage_data[(k-1)*WIDTH +: WIDTH]),
                .prev_valid (stage_valid[k-1]),
                .data       (stage_data[k*WIDTH +: WIDTH]),
                .valid      (stage_valid[k])
            );
        end
    end

`ifdef PIPE_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A stage receives an inserted bubble when it is neither flushed nor held
    // but its upstream neighbour is held; stage 0 has no upstream neighbour.
    logic [DEPTH-1:0] bubble_ins;
    logic             bubble_evt;

    always_comb begin
        bubble_ins = '0;
        for (int k = 1; k < DEPTH; k++) begin
            bubble_ins[k] = ~flush_i[k] & ~hold[k] & hold[k-1];
        end
        bubble_evt = |(bubble_ins | (flush_i & stage_valid));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!in_ready) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (bubble_evt) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end
`endif

endmodule : pipe_reg_chain

// File: tb/tb_pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_chain
// Directed bench for pipe_reg_chain with WIDTH=8, DEPTH=4, BUBBLE_VAL=0.
// Counter checks are included when PIPE_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_reg_chain;
    import pipe_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   reset;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall_i;
    logic [DEPTH-1:0]       flush_i;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [DEPTH-1:0]       stage_valid;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0]            stall_cnt;
    logic [15:0]            bubble_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_reg_chain #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .BUBBLE_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stage_data  (stage_data),
        .stage_valid (stage_valid)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d, input logic v, input logic [3:0] st, input logic [3:0] fl);
        in_data  = d;
        in_valid = v;
        stall_i  = st;
        flush_i  = fl;
        tick();
    endtask

    task automatic chk_cnt(input string tag, input int exp_stall, input int exp_bubble);
`ifdef PIPE_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "_bubble_cnt"}, 32'(bubble_cnt), 32'(exp_bubble));
`else
        if (exp_stall < 0 || exp_bubble < 0) $display("bad counter expectation in %s", tag);
`endif
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        stall_i  = '0;
        flush_i  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_data", stage_data, 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk_cnt("rst", 0, 0);

        // Streaming: 11,22,33,44 back to back
        feed(8'h11, 1'b1, 4'b0000, 4'b0000);
        chk("stream_s0", 32'(stage_data[STG_FD*WIDTH +: WIDTH]), 32'h11);
        feed(8'h22, 1'b1, 4'b0000, 4'b0000);
        feed(8'h33, 1'b1, 4'b0000, 4'b0000);
        feed(8'h44, 1'b1, 4'b0000, 4'b0000);
        chk("stream_s3", 32'(stage_data[STG_MW*WIDTH +: WIDTH]), 32'h11);
        chk("stream_full", stage_data, 32'h11223344);
        chk("stream_valid", 32'(stage_valid), 32'hF);
        feed(8'h99, 1'b0, 4'b0000, 4'b0000);
        chk("invalid_entry_data", stage_data, 32'h22334400);
        chk("invalid_entry_valid", 32'(stage_valid), 32'hE);
        feed(8'h00, 1'b0, 4'b0000, 4'b0000);
        feed(8'h00, 1'b0, 4'b0000, 4'b0000);
        chk("stream_44_s3", stage_data, 32'h44000000);
        chk("stream_44_valid", 32'(stage_valid), 32'h8);
        feed(8'h00, 1'b0, 4'b0000, 4'b0000);
        chk("drained_valid", 32'(stage_valid), 32'h0);
        chk_cnt("stream", 0, 0);

        // Load-use: A1 in stage 1, stall_i=0010 with flush_i=0100
        feed(8'hB0, 1'b1, 4'b0000, 4'b0000);
        feed(8'hA1, 1'b1, 4'b0000, 4'b0000);
        feed(8'hB2, 1'b1, 4'b0000, 4'b0000);
        chk("lu_pre", stage_data, 32'h00B0A1B2);
        in_data  = 8'hC3;
        in_valid = 1'b1;
        stall_i  = 4'b0010;
        flush_i  = 4'b0100;
        #1;
        chk("lu_ready", 32'(in_ready), 32'h0);
        tick();
        chk("lu_data", stage_data, 32'hB000A1B2);
        chk("lu_valid", 32'(stage_valid), 32'hB);
        chk_cnt("lu", 1, 1);
        feed(8'hC3, 1'b1, 4'b0000, 4'b0000);
        chk("lu_after_data", stage_data, 32'h00A1B2C3);
        chk("lu_after_valid", 32'(stage_valid), 32'h7);
        chk("lu_after_ready", 32'(in_ready), 32'h1);

        // Stall on stage 0 only: bubble inserted into stage 1
        feed(8'hD4, 1'b1, 4'b0001, 4'b0000);
        chk("st0_data", stage_data, 32'hA1B200C3);
        chk("st0_valid", 32'(stage_valid), 32'hD);
        chk_cnt("st0", 2, 2);

        // Branch flush of stages 0 and 1
        feed(8'hD4, 1'b1, 4'b0000, 4'b0000);
        chk("bf_pre_valid", 32'(stage_valid), 32'hB);
        feed(8'hE5, 1'b1, 4'b0000, 4'b0011);
        chk("bf_data", stage_data, 32'h00C30000);
        chk("bf_valid", 32'(stage_valid), 32'h4);
        chk_cnt("bf", 2, 3);

        // Flush beats stall on stage 1
        feed(8'hF6, 1'b1, 4'b0000, 4'b0000);
        feed(8'h07, 1'b1, 4'b0000, 4'b0000);
        chk("fbs_pre", stage_data, 32'h0000F607);
        feed(8'h18, 1'b1, 4'b0010, 4'b0010);
        chk("fbs_data", stage_data, 32'h00000007);
        chk("fbs_valid", 32'(stage_valid), 32'h1);
        chk_cnt("fbs", 3, 4);

        // Fill, freeze, then reset mid-stall
        feed(8'h5C, 1'b1, 4'b0000, 4'b0000);
        feed(8'h4B, 1'b1, 4'b0000, 4'b0000);
        feed(8'h3A, 1'b1, 4'b0000, 4'b0000);
        feed(8'h29, 1'b1, 4'b0000, 4'b0000);
        chk("fill_data", stage_data, 32'h5C4B3A29);
        feed(8'h6D, 1'b1, 4'b1111, 4'b0000);
        chk("frozen_data", stage_data, 32'h5C4B3A29);
        chk("frozen_valid", 32'(stage_valid), 32'hF);
        chk_cnt("frozen", 4, 4);
        reset = 1'b1;
        feed(8'h6D, 1'b1, 4'b1111, 4'b0000);
        reset = 1'b0;
        chk("rst_stall_valid", 32'(stage_valid), 32'h0);
        chk("rst_stall_data", stage_data, 32'h0);
        chk("rst_stall_ready", 32'(in_ready), 32'h0);
        chk_cnt("rst_stall", 0, 0);
        feed(8'h6D, 1'b1, 4'b1111, 4'b0000);
        feed(8'h6D, 1'b1, 4'b1111, 4'b0000);
        chk("post_rst_valid", 32'(stage_valid), 32'h0);
        chk_cnt("post_rst", 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_reg_chain
